// File: rtl/puf_multi_sequencer_if.sv
// Control/response bundle between a host and the multi-channel RO-PUF sequencer.
// The slave side is the sequencer; the master side issues runs and supplies resp_bit.
interface puf_multi_sequencer_if #(
    parameter int NUM_CHANNELS     = 2,
    parameter int NUM_LOOPS        = 4,
    parameter int CHALLENGE_BITS   = 4,
    parameter int REPETITIONS_BITS = 16,
    parameter int EVAL_TIME_BITS   = 16
);
    localparam int SEL_W = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;

    logic                        start;
    logic                        abort;
    logic [CHALLENGE_BITS-1:0]   challenge;
    logic [REPETITIONS_BITS-1:0] repetitions;
    logic [EVAL_TIME_BITS-1:0]   eval_time;
    logic [NUM_CHANNELS-1:0]     resp_bit;
    logic                        busy;
    logic                        done;
    logic                        reset_puf;
    logic [SEL_W-1:0]            select_puf;
    logic                        enable_puf;
    logic                        store_response_puf;
    logic [NUM_CHANNELS-1:0]     response;
    logic [NUM_CHANNELS-1:0]     tie;

    modport master (
        output start, abort, challenge, repetitions, eval_time, resp_bit,
        input  busy, done, reset_puf, select_puf, enable_puf, store_response_puf, response, tie
    );

    modport slave (
        input  start, abort, challenge, repetitions, eval_time, resp_bit,
        output busy, done, reset_puf, select_puf, enable_puf, store_response_puf, response, tie
    );
endinterface

// File: rtl/puf_multi_sequencer.sv
// Lockstep sequencer for NUM_CHANNELS ring-oscillator PUF arrays: per repetition it runs
// reset/eval/store/sample, then majority-votes each channel's response over all repetitions.
module puf_multi_sequencer #(
    parameter int NUM_CHANNELS     = 2,
    parameter int NUM_LOOPS        = 4,
    parameter int CHALLENGE_BITS   = 4,
    parameter int REPETITIONS_BITS = 16,
    parameter int EVAL_TIME_BITS   = 16,
    parameter int SETTLE_TIME      = 2
) (
    input logic                  clk,
    input logic                  reset,
    puf_multi_sequencer_if.slave bus
);
    localparam int SEL_W = (NUM_LOOPS > 1) ? $clog2(NUM_LOOPS) : 1;
    localparam int SEL_USED = (SEL_W < CHALLENGE_BITS) ? SEL_W : CHALLENGE_BITS;
    localparam int RB = REPETITIONS_BITS;
    localparam int EB = EVAL_TIME_BITS;

    typedef enum logic [2:0] {
        S_IDLE, S_RESET_PUF, S_EVAL, S_STORE, S_SAMPLE, S_DONE
    } state_t;

    state_t                  state;
    logic [EB-1:0]           timer;
    logic [EB-1:0]           eval_last;
    logic [RB-1:0]           reps_q;
    logic [RB-1:0]           rep_cnt;
    logic [RB-1:0]           rep_nxt;
    logic [RB-1:0]           ones     [NUM_CHANNELS];
    logic [RB-1:0]           ones_nxt [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] resp_nxt;
    logic [NUM_CHANNELS-1:0] tie_nxt;
    logic [SEL_W-1:0]        sel_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    reset_puf_q;
    logic                    enable_q;
    logic                    store_q;
    logic [NUM_CHANNELS-1:0] response_q;
    logic [NUM_CHANNELS-1:0] tie_q;

    // Vote uses the counts including the sample being taken this cycle; 2*ones vs reps in RB+1 bits.
    always_comb begin
        rep_nxt  = rep_cnt + RB'(1);
        resp_nxt = '0;
        tie_nxt  = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            ones_nxt[i] = ones[i] + RB'(bus.resp_bit[i]);
            resp_nxt[i] = {ones_nxt[i], 1'b0} >  {1'b0, reps_q};
            tie_nxt[i]  = {ones_nxt[i], 1'b0} == {1'b0, reps_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            eval_last   <= '0;
            reps_q      <= '0;
            rep_cnt     <= '0;
            sel_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reset_puf_q <= 1'b0;
            enable_q    <= 1'b0;
            store_q     <= 1'b0;
            response_q  <= '0;
            tie_q       <= '0;
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) ones[i] <= '0;
        end else if (bus.abort && (state inside {S_RESET_PUF, S_EVAL, S_STORE, S_SAMPLE})) begin
            state       <= S_IDLE;
            busy_q      <= 1'b0;
            reset_puf_q <= 1'b0;
            enable_q    <= 1'b0;
            store_q     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state       <= S_RESET_PUF;
                        busy_q      <= 1'b1;
                        reset_puf_q <= 1'b1;
                        timer       <= '0;
                        rep_cnt     <= '0;
                        sel_q       <= SEL_W'(bus.challenge[SEL_USED-1:0]);
                        reps_q      <= (bus.repetitions == '0) ? RB'(1) : bus.repetitions;
                        eval_last   <= (bus.eval_time == '0) ? '0 : bus.eval_time - EB'(1);
                        for (int unsigned i = 0; i < NUM_CHANNELS; i++) ones[i] <= '0;
                    end
                end
                S_RESET_PUF: begin
                    if (timer == EB'(SETTLE_TIME - 1)) begin
                        state       <= S_EVAL;
                        timer       <= '0;
                        reset_puf_q <= 1'b0;
                        enable_q    <= 1'b1;
                    end else begin
                        timer <= timer + EB'(1);
                    end
                end
                S_EVAL: begin
                    if (timer == eval_last) begin
                        state    <= S_STORE;
                        enable_q <= 1'b0;
                        store_q  <= 1'b1;
                    end else begin
                        timer <= timer + EB'(1);
                    end
                end
                S_STORE: begin
                    state   <= S_SAMPLE;
                    store_q <= 1'b0;
                end
                S_SAMPLE: begin
                    for (int unsigned i = 0; i < NUM_CHANNELS; i++) ones[i] <= ones_nxt[i];
                    rep_cnt <= rep_nxt;
                    if (rep_nxt == reps_q) begin
                        state      <= S_DONE;
                        done_q     <= 1'b1;
                        response_q <= resp_nxt;
                        tie_q      <= tie_nxt;
                    end else begin
                        state       <= S_RESET_PUF;
                        reset_puf_q <= 1'b1;
                        timer       <= '0;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy               = busy_q;
    assign bus.done               = done_q;
    assign bus.reset_puf          = reset_puf_q;
    assign bus.select_puf         = sel_q;
    assign bus.enable_puf         = enable_q;
    assign bus.store_response_puf = store_q;
    assign bus.response           = response_q;
    assign bus.tie                = tie_q;
endmodule
